// File: rtl/bcd_pkg.sv
// Shared widths and state encodings for the binary-to-BCD scheduler.
// Optional feature macro used by bcd_convert_sched: BCD_SCHED_CACHE_EN.
package bcd_pkg;

   localparam int unsigned BIN_W = 8;
   localparam int unsigned DIG_W = 4;
   localparam int unsigned BCD_W = 12;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } sched_state_e;

   typedef enum logic [1:0] {
      C_LOAD = 2'd0,
      C_HUND = 2'd1,
      C_TENS = 2'd2
   } core_state_e;

endpackage

// File: rtl/bcd_iter_core.sv
// Iterative subtract-based binary-to-BCD converter (0..255 -> 3 digits).
// Takes 3 + hundreds + tens cycles from the start cycle to the done pulse.
module bcd_iter_core
   import bcd_pkg::*;
(
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [BIN_W-1:0] bin_i,
   output logic             done_o,
   output logic [DIG_W-1:0] hund_o,
   output logic [DIG_W-1:0] tens_o,
   output logic [DIG_W-1:0] ones_o
);

   core_state_e      state_q;
   logic [BIN_W-1:0] a_q;
   logic [DIG_W-1:0] cnt_q;
   logic             done_q;
   logic [DIG_W-1:0] hund_q;
   logic [DIG_W-1:0] tens_q;
   logic [DIG_W-1:0] ones_q;

   // Load on start, then peel off hundreds and tens by repeated subtraction.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= C_LOAD;
         a_q     <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         hund_q  <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            C_LOAD: begin
               if (start_i) begin
                  a_q     <= bin_i;
                  cnt_q   <= '0;
                  state_q <= C_HUND;
               end
            end
            C_HUND: begin
               if (a_q >= BIN_W'(100)) begin
                  a_q   <= a_q - BIN_W'(100);
                  cnt_q <= cnt_q + DIG_W'(1);
               end else begin
                  hund_q  <= cnt_q;
                  cnt_q   <= '0;
                  state_q <= C_TENS;
               end
            end
            C_TENS: begin
               if (a_q >= BIN_W'(10)) begin
                  a_q   <= a_q - BIN_W'(10);
                  cnt_q <= cnt_q + DIG_W'(1);
               end else begin
                  tens_q  <= cnt_q;
                  ones_q  <= a_q[DIG_W-1:0];
                  done_q  <= 1'b1;
                  state_q <= C_LOAD;
               end
            end
            default: state_q <= C_LOAD;
         endcase
      end
   end

   assign done_o = done_q;
   assign hund_o = hund_q;
   assign tens_o = tens_q;
   assign ones_o = ones_q;

endmodule

// File: rtl/bcd_convert_sched.sv
// Round-robin scheduler sharing one bcd_iter_core among NCH channels and
// holding the latest 3-digit BCD result per channel.
// Optional: define BCD_SCHED_CACHE_EN to skip conversion when a channel
// re-requests the same binary value it last converted.
module bcd_convert_sched
   import bcd_pkg::*;
#(
   parameter int unsigned NCH = 4
)
(
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic [NCH-1:0]       req_i,
   input  logic [NCH*BIN_W-1:0] bin_i,
   output logic [NCH-1:0]       ack_o,
   output logic [NCH-1:0]       valid_o,
   output logic [NCH*BCD_W-1:0] bcd_o,
   output logic                 busy_o
);

   localparam int unsigned PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

   sched_state_e                  state_q;
   logic [PTR_W-1:0]              ptr_q;
   logic [PTR_W-1:0]              gnt_q;
   logic [NCH-1:0]                ack_q;
   logic [NCH-1:0]                valid_q;
   logic [NCH-1:0][BCD_W-1:0]     bcd_q;
   logic                          busy_q;

   logic [NCH-1:0][BIN_W-1:0]     bin_arr_c;
   logic                          found_c;
   logic [PTR_W-1:0]              gsel_c;
   logic                          start_c;

   logic                          core_done;
   logic [DIG_W-1:0]              core_hund;
   logic [DIG_W-1:0]              core_tens;
   logic [DIG_W-1:0]              core_ones;

   assign bin_arr_c = bin_i;

   // Pick the first requesting channel at or after the rr pointer, wrapping.
   always_comb begin
      found_c = 1'b0;
      gsel_c  = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (!found_c && req_i[PTR_W'((32'(ptr_q) + k) % NCH)]) begin
            found_c = 1'b1;
            gsel_c  = PTR_W'((32'(ptr_q) + k) % NCH);
         end
      end
   end

`ifdef BCD_SCHED_CACHE_EN
   logic [NCH-1:0][BIN_W-1:0]     last_bin_q;
   logic [NCH-1:0]                seen_q;
   logic                          hit_q;
   logic [BIN_W-1:0]              bin_lat_q;
   logic                          hit_c;

   assign hit_c   = seen_q[gsel_c] && (bin_arr_c[gsel_c] == last_bin_q[gsel_c]);
   assign start_c = (state_q == S_IDLE) && found_c && !hit_c;
`else
   assign start_c = (state_q == S_IDLE) && found_c;
`endif

   // The core latches the granted bin in the same edge that raises ack.
   bcd_iter_core u_core (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .start_i (start_c),
      .bin_i   (bin_arr_c[gsel_c]),
      .done_o  (core_done),
      .hund_o  (core_hund),
      .tens_o  (core_tens),
      .ones_o  (core_ones)
   );

   // Scheduler FSM: grant in IDLE, wait in CONV, publish the result in DONE.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         gnt_q      <= '0;
         ack_q      <= '0;
         valid_q    <= '0;
         bcd_q      <= '0;
         busy_q     <= 1'b0;
`ifdef BCD_SCHED_CACHE_EN
         last_bin_q <= '0;
         seen_q     <= '0;
         hit_q      <= 1'b0;
         bin_lat_q  <= '0;
`endif
      end else begin
         ack_q   <= '0;
         valid_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (found_c) begin
                  ack_q[gsel_c] <= 1'b1;
                  gnt_q         <= gsel_c;
                  busy_q        <= 1'b1;
`ifdef BCD_SCHED_CACHE_EN
                  hit_q         <= hit_c;
                  bin_lat_q     <= bin_arr_c[gsel_c];
                  state_q       <= hit_c ? S_DONE : S_CONV;
`else
                  state_q       <= S_CONV;
`endif
               end
            end
            S_CONV: begin
               if (core_done) begin
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
`ifdef BCD_SCHED_CACHE_EN
               if (!hit_q) begin
                  bcd_q[gnt_q]      <= {core_hund, core_tens, core_ones};
                  last_bin_q[gnt_q] <= bin_lat_q;
                  seen_q[gnt_q]     <= 1'b1;
               end
`else
               bcd_q[gnt_q]   <= {core_hund, core_tens, core_ones};
`endif
               valid_q[gnt_q] <= 1'b1;
               ptr_q          <= (gnt_q == PTR_W'(NCH - 1)) ? '0 : gnt_q + PTR_W'(1);
               busy_q         <= 1'b0;
               state_q        <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ack_o   = ack_q;
   assign valid_o = valid_q;
   assign bcd_o   = bcd_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_bcd_convert_sched.sv
// Directed self-checking bench for bcd_convert_sched (NCH=4).
// Honours BCD_SCHED_CACHE_EN for the cache re-request latency.
module tb_bcd_convert_sched;
   import bcd_pkg::*;

   localparam int unsigned NCH = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NCH-1:0]       req;
   logic [NCH*BIN_W-1:0] bin;
   logic [NCH-1:0]       ack;
   logic [NCH-1:0]       valid;
   logic [NCH*BCD_W-1:0] bcd;
   logic                 busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [BCD_W-1:0] exp_bcd [NCH];

   int viol        = 0;
   int valid_total = 0;
   int ack_cnt   [NCH];
   int valid_cnt [NCH];
   logic prev_busy = 1'b0;

   bcd_convert_sched #(.NCH(NCH)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .req_i   (req),
      .bin_i   (bin),
      .ack_o   (ack),
      .valid_o (valid),
      .bcd_o   (bcd),
      .busy_o  (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Protocol monitor: ack one-hot, never with valid, never while already busy.
   initial begin
      for (int i = 0; i < NCH; i++) begin
         ack_cnt[i]   = 0;
         valid_cnt[i] = 0;
      end
   end
   always @(negedge clk) begin
      if (ack != '0) begin
         if (prev_busy || valid != '0 || !$onehot(ack)) viol++;
      end
      for (int i = 0; i < NCH; i++) begin
         if (ack[i])   ack_cnt[i]++;
         if (valid[i]) begin
            valid_cnt[i]++;
            valid_total++;
         end
      end
      prev_busy = busy;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_vec();
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < NCH; i++) v[i*BCD_W +: BCD_W] = exp_bcd[i];
      return v;
   endfunction

   task automatic wait_ack(input int ch, output int t);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!ack[ch] && t < 30);
   endtask

   task automatic wait_valid(input int ch, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!valid[ch] && lat < 40);
   endtask

   // Single-channel request: check ack, ack-to-valid latency and all results.
   task automatic do_conv(input string tag, input int ch, input logic [7:0] b,
                          input int exp_lat, input logic [11:0] exp_res);
      int t, lat;
      @(negedge clk);
      bin[ch*BIN_W +: BIN_W] = b;
      req[ch] = 1'b1;
      wait_ack(ch, t);
      check_eq({tag, "_ack"}, 64'(ack[ch]), 64'd1);
      req[ch] = 1'b0;
      wait_valid(ch, lat);
      exp_bcd[ch] = exp_res;
      check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, "_bcd"}, 64'(bcd), exp_vec());
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NCH; i++) exp_bcd[i] = '0;
   endtask

   initial begin
      int t, lat, ch, v0, a2, v2;
      int exp_ord [5] = '{0, 1, 2, 3, 0};
      req = '0;
      bin = '0;
      rst = 1'b1;
      do_reset();

      // Reset state
      check_eq("rst_ack",   64'(ack),   64'd0);
      check_eq("rst_valid", 64'(valid), 64'd0);
      check_eq("rst_bcd",   64'(bcd),   64'd0);
      check_eq("rst_busy",  64'(busy),  64'd0);

      // Basic conversion and boundaries
      do_conv("b173", 0, 8'd173, 12, 12'h173);
      do_conv("b0",   1, 8'd0,   4,  12'h000);
      do_conv("b255", 2, 8'd255, 11, 12'h255);
      do_conv("b100", 3, 8'd100, 5,  12'h100);
      do_conv("b99",  0, 8'd99,  13, 12'h099);

      // All channels held high: round robin 0,1,2,3,0
      do_reset();
      @(negedge clk);
      bin = {4{8'd42}};
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (ack == '0 && t < 30);
         ch = 0;
         for (int k = 0; k < NCH; k++) if (ack[k]) ch = k;
         check_eq($sformatf("rr_grant%0d", i), 64'(ack), 64'(1) << exp_ord[i]);
         if (i == 4) req = '0;
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (valid == '0 && t < 40);
         check_eq($sformatf("rr_valid%0d", i), 64'(valid), 64'(1) << exp_ord[i]);
         exp_bcd[exp_ord[i]] = 12'h042;
         check_eq($sformatf("rr_bcd%0d", i), 64'(bcd), exp_vec());
      end

      // Reset five cycles into a bin=255 conversion
      @(negedge clk);
      bin[2*BIN_W +: BIN_W] = 8'd255;
      req[2] = 1'b1;
      wait_ack(2, t);
      check_eq("mid_ack", 64'(ack[2]), 64'd1);
      req[2] = 1'b0;
      repeat (5) @(negedge clk);
      v0 = valid_total;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("mid_rst_bcd",  64'(bcd),  64'd0);
      check_eq("mid_rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < NCH; i++) exp_bcd[i] = '0;
      repeat (18) @(negedge clk);
      check_eq("mid_no_valid", 64'(valid_total - v0), 64'd0);
      check_eq("mid_bcd_zero", 64'(bcd), 64'd0);
      bin = {4{8'd42}};
      req = 4'b1111;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (ack == '0 && t < 30);
      check_eq("mid_next_grant", 64'(ack), 64'b0001);
      req = '0;
      wait_valid(0, lat);
      exp_bcd[0] = 12'h042;
      check_eq("mid_next_bcd", 64'(bcd), exp_vec());

      // Short req[2] pulse during a ch1 conversion is cancelled
      a2 = ack_cnt[2];
      v2 = valid_cnt[2];
      @(negedge clk);
      bin[1*BIN_W +: BIN_W] = 8'd199;
      req[1] = 1'b1;
      wait_ack(1, t);
      check_eq("drop_ack1", 64'(ack[1]), 64'd1);
      req[1] = 1'b0;
      repeat (3) @(negedge clk);
      bin[2*BIN_W +: BIN_W] = 8'd77;
      req[2] = 1'b1;
      @(negedge clk);
      req[2] = 1'b0;
      lat = 4;
      do begin
         @(negedge clk);
         lat++;
      end while (!valid[1] && lat < 40);
      exp_bcd[1] = 12'h199;
      check_eq("drop_lat199", 64'(lat), 64'd14);
      check_eq("drop_bcd", 64'(bcd), exp_vec());
      repeat (10) @(negedge clk);
      check_eq("drop_no_ack2",   64'(ack_cnt[2] - a2),   64'd0);
      check_eq("drop_no_valid2", 64'(valid_cnt[2] - v2), 64'd0);
      check_eq("drop_bcd_hold",  64'(bcd), exp_vec());

      // Re-request of the same value on ch3
      do_conv("c200a", 3, 8'd200, 6, 12'h200);
`ifdef BCD_SCHED_CACHE_EN
      do_conv("c200b", 3, 8'd200, 1, 12'h200);
`else
      do_conv("c200b", 3, 8'd200, 6, 12'h200);
`endif

      repeat (3) @(negedge clk);
      check_eq("protocol_viol", 64'(viol), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
